// File: rtl/microcode_pkg.sv
// Shared types and the default microcode image for the microcode sequencer.
// Conditional early exit is enabled by defining UCODE_COND_EXIT_EN.
package microcode_pkg;

  localparam int unsigned OPCODE_W_DEF = 4;
  localparam int unsigned STEP_W_DEF   = 3;
  localparam int unsigned CTRL_W_DEF   = 10;
  localparam logic [OPCODE_W_DEF-1:0] HALT_OP_DEF = 4'hF;

  localparam int unsigned UCODE_OPS    = 16;
  localparam int unsigned UCODE_STEPS  = 8;
  localparam int unsigned UCODE_DEPTH  = UCODE_OPS * UCODE_STEPS;
  localparam int unsigned UCODE_ADDR_W = 7;

  typedef enum logic [1:0] {
    COND_NONE  = 2'b00,
    COND_CARRY = 2'b01,
    COND_ZERO  = 2'b10,
    COND_RSVD  = 2'b11
  } cond_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic                  end_step;
    cond_e                 cond;
    logic                  halt;
  } uword_t;

  function automatic uword_t mk_uword(logic [CTRL_W_DEF-1:0] ctrl, logic end_step,
                                      cond_e cond, logic halt);
    uword_t w;
    w.ctrl     = ctrl;
    w.end_step = end_step;
    w.cond     = cond;
    w.halt     = halt;
    return w;
  endfunction

  // Index is op*8 + step; unlisted entries are all-zero microwords.
  localparam uword_t UCODE_TABLE [UCODE_DEPTH] = '{
    0:       mk_uword(10'h0AA, 1'b0, COND_NONE,  1'b0),
    1:       mk_uword(10'h1AA, 1'b1, COND_NONE,  1'b0),
    24:      mk_uword(10'h092, 1'b0, COND_NONE,  1'b0),
    25:      mk_uword(10'h062, 1'b0, COND_CARRY, 1'b0),
    26:      mk_uword(10'h0AC, 1'b0, COND_NONE,  1'b0),
    27:      mk_uword(10'h0AE, 1'b1, COND_NONE,  1'b0),
    120:     mk_uword(10'h000, 1'b0, COND_NONE,  1'b1),
    default: '0
  };

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode store indexed by {op, step}.
module microcode_rom
  import microcode_pkg::*;
#(
  parameter int unsigned OPCODE_W = OPCODE_W_DEF,
  parameter int unsigned STEP_W   = STEP_W_DEF,
  parameter logic [OPCODE_W-1:0] HALT_OP = OPCODE_W'(HALT_OP_DEF)
) (
  input  logic [OPCODE_W-1:0] op_i,
  input  logic [STEP_W-1:0]   step_i,
  output uword_t              uword_o
);

  logic [31:0] op_idx;
  logic [31:0] step_idx;

  assign op_idx   = 32'(op_i);
  assign step_idx = 32'(step_i);

  // Addresses outside the default image read as empty microwords.
  always_comb begin
    uword_o = '0;
    if ((op_idx < UCODE_OPS) && (step_idx < UCODE_STEPS)) begin
      uword_o = UCODE_TABLE[UCODE_ADDR_W'(op_idx * UCODE_STEPS + step_idx)];
    end
    if ((op_i == HALT_OP) && (step_i == '0)) begin
      uword_o.halt = 1'b1;
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// FETCH/EXEC/HALT microcode sequencer with back-to-back instruction issue.
// Define UCODE_COND_EXIT_EN to let the microword cond field end an instruction early.
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int unsigned OPCODE_W = OPCODE_W_DEF,
  parameter int unsigned STEP_W   = STEP_W_DEF,
  parameter int unsigned CTRL_W   = CTRL_W_DEF,
  parameter logic [OPCODE_W-1:0] HALT_OP = OPCODE_W'(HALT_OP_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                opcode_valid_i,
  input  logic [1:0]          flags_i,
  input  logic                stall_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [STEP_W-1:0]   step_o,
  output logic                fetch_o,
  output logic                halted_o,
  output logic                ucode_err_o
);

  state_e               state_q, state_d;
  logic [OPCODE_W-1:0]  op_q, op_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 err_q, err_d;

  uword_t uw;
  logic   cond_hit;
  logic   overflow;
  logic   term;
  logic   exec_live;
  logic   accept;

  microcode_rom #(
    .OPCODE_W (OPCODE_W),
    .STEP_W   (STEP_W),
    .HALT_OP  (HALT_OP)
  ) u_rom (
    .op_i    (op_q),
    .step_i  (step_q),
    .uword_o (uw)
  );

`ifdef UCODE_COND_EXIT_EN
  always_comb begin
    cond_hit = 1'b0;
    case (uw.cond)
      COND_CARRY: cond_hit = flags_i[0];
      COND_ZERO:  cond_hit = flags_i[1];
      default:    cond_hit = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^{flags_i, uw.cond};
  assign cond_hit    = 1'b0;
`endif

  // Step decode: flags only matter on an unstalled EXEC cycle.
  always_comb begin
    exec_live = (state_q == ST_EXEC) && !stall_i;
    overflow  = (step_q == '1);
    term      = uw.end_step || cond_hit || overflow;
    fetch_o   = ((state_q == ST_FETCH) && !stall_i) || (exec_live && !uw.halt && term);
    accept    = fetch_o && opcode_valid_i;
    ctrl_o    = (state_q == ST_EXEC) ? CTRL_W'(uw.ctrl) : '0;
  end

  assign step_o      = step_q;
  assign halted_o    = (state_q == ST_HALT);
  assign ucode_err_o = err_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    err_d   = err_q;
    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          op_d    = opcode_i;
          step_d  = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_live) begin
          if (uw.halt) begin
            state_d = ST_HALT;
          end else if (term) begin
            // Running off the last step with no end/cond is a microcode bug.
            if (overflow && !uw.end_step && !cond_hit) begin
              err_d = 1'b1;
            end
            step_d = '0;
            if (accept) begin
              op_d = opcode_i;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      step_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized self-checking bench for microcode_sequencer with a spec-level reference model.
// Honours UCODE_COND_EXIT_EN the same way as the design.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode_i;
  logic       opcode_valid_i;
  logic [1:0] flags_i;
  logic       stall_i;
  logic [9:0] ctrl_o;
  logic [2:0] step_o;
  logic       fetch_o;
  logic       halted_o;
  logic       ucode_err_o;

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode_i       (opcode_i),
    .opcode_valid_i (opcode_valid_i),
    .flags_i        (flags_i),
    .stall_i        (stall_i),
    .ctrl_o         (ctrl_o),
    .step_o         (step_o),
    .fetch_o        (fetch_o),
    .halted_o       (halted_o),
    .ucode_err_o    (ucode_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode -1 unknown, 0 waiting for opcode, 1 running, 2 halted.
  int m_mode = -1;
  int m_op   = 0;
  int m_step = 0;
  int m_err  = 0;

  int s_ctrl, s_step, s_fetch, s_halt, s_err;

  function automatic void ref_word(input int op, input int st, output int ctrl,
                                   output int e, output int cond, output int h);
    int op3_ctrl[4] = '{'h092, 'h062, 'h0AC, 'h0AE};
    ctrl = 0; e = 0; cond = 0; h = 0;
    case (op)
      0: begin
        if (st == 0) ctrl = 'h0AA;
        if (st == 1) begin ctrl = 'h1AA; e = 1; end
      end
      3: begin
        if (st < 4) ctrl = op3_ctrl[st];
        if (st == 1) cond = 1;
        if (st == 3) e = 1;
      end
      15: if (st == 0) h = 1;
      default: ;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, sample mid-cycle, compare with model, then advance model.
  task automatic tick(input int rst, input int valid, input int op, input int fl, input int stall);
    int ctrl, e, cond, h, hit, term, e_fetch, e_ctrl;
    rst_n          = rst[0];
    opcode_valid_i = valid[0];
    opcode_i       = 4'(op);
    flags_i        = 2'(fl);
    stall_i        = stall[0];
    @(negedge clk);
    s_ctrl  = int'(ctrl_o);
    s_step  = int'(step_o);
    s_fetch = int'(fetch_o);
    s_halt  = int'(halted_o);
    s_err   = int'(ucode_err_o);

    ref_word(m_op, m_step, ctrl, e, cond, h);
    hit = 0;
`ifdef UCODE_COND_EXIT_EN
    if (cond == 1 && fl[0]) hit = 1;
    if (cond == 2 && fl[1]) hit = 1;
`endif
    term    = (e != 0 || hit != 0 || m_step == 7) ? 1 : 0;
    e_fetch = 0;
    if (m_mode == 0 && stall == 0) e_fetch = 1;
    if (m_mode == 1 && stall == 0 && h == 0 && term != 0) e_fetch = 1;
    e_ctrl  = (m_mode == 1) ? ctrl : 0;

    if (m_mode >= 0) begin
      chk("ctrl_o", s_ctrl, e_ctrl);
      chk("step_o", s_step, m_step);
      chk("fetch_o", s_fetch, e_fetch);
      chk("halted_o", s_halt, (m_mode == 2) ? 1 : 0);
      chk("ucode_err_o", s_err, m_err);
    end

    if (rst == 0) begin
      m_mode = 0; m_op = 0; m_step = 0; m_err = 0;
    end else if (m_mode == 0) begin
      if (e_fetch != 0 && valid != 0) begin
        m_mode = 1; m_op = op; m_step = 0;
      end
    end else if (m_mode == 1 && stall == 0) begin
      if (h != 0) begin
        m_mode = 2;
      end else if (term != 0) begin
        if (m_step == 7 && e == 0 && hit == 0) m_err = 1;
        m_step = 0;
        if (valid != 0) m_op = op;
        else m_mode = 0;
      end else begin
        m_step = m_step + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Accept op from FETCH, then count EXEC cycles until the terminating step.
  task automatic run_len(input int op, input int fl, output int len);
    len = 0;
    tick(1, 1, op, fl, 0);
    for (int i = 0; i < 16; i++) begin
      tick(1, 0, 0, fl, 0);
      len++;
      if (s_fetch != 0) break;
    end
  endtask

  initial begin
    int len, exp_carry_len, r, op;
    rst_n = 1'b0; opcode_i = '0; opcode_valid_i = 1'b0; flags_i = '0; stall_i = 1'b0;
#1;
`ifdef UCODE_COND_EXIT_EN
    exp_carry_len = 2;
`else
    exp_carry_len = 4;
`endif

    tick(0, 0, 0, 0, 0);
    tick(0, 1, 3, 3, 1);
    tick(1, 0, 0, 0, 0);
    chk("rst_ctrl", s_ctrl, 0);
    chk("rst_step", s_step, 0);
    chk("rst_fetch", s_fetch, 1);
    chk("rst_halted", s_halt, 0);
    chk("rst_err", s_err, 0);

    // single op 0
    tick(1, 1, 0, 0, 0);
    chk("op0_accept_fetch", s_fetch, 1);
    tick(1, 0, 0, 0, 0);
    chk("op0_s0_ctrl", s_ctrl, 'h0AA);
    chk("op0_s0_fetch", s_fetch, 0);
    tick(1, 0, 0, 0, 0);
    chk("op0_s1_ctrl", s_ctrl, 'h1AA);
    chk("op0_s1_fetch", s_fetch, 1);
    tick(1, 0, 0, 0, 0);
    chk("op0_fetch_ctrl", s_ctrl, 0);

    // back-to-back op 0
    tick(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, (i < 2) ? 1 : 0, 0, 0, 0);
      chk("b2b_step", s_step, i % 2);
      chk("b2b_ctrl", s_ctrl, (i % 2 == 1) ? 'h1AA : 'h0AA);
    end
    tick(1, 0, 0, 0, 0);

    run_len(3, 1, len);
    chk("op3_carry_len", len, exp_carry_len);
    run_len(3, 0, len);
    chk("op3_noflag_len", len, 4);
    run_len(3, 2, len);
    chk("op3_zeroflag_len", len, 4);

    // stall at step 2
    tick(1, 1, 3, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 1);
      chk("stall_ctrl", s_ctrl, 'h0AC);
      chk("stall_fetch", s_fetch, 0);
      chk("stall_step", s_step, 2);
    end
    tick(1, 0, 0, 0, 0);
    chk("resume_ctrl", s_ctrl, 'h0AC);
    tick(1, 0, 0, 0, 0);
    chk("resume_s3_ctrl", s_ctrl, 'h0AE);
    chk("resume_s3_fetch", s_fetch, 1);

    // stall in FETCH blocks accept
    tick(1, 1, 0, 0, 1);
    chk("fetch_stall", s_fetch, 0);
    tick(1, 0, 0, 0, 0);
    chk("fetch_after_stall", s_fetch, 1);
    chk("fetch_after_stall_ctrl", s_ctrl, 0);

    // overflow on op 5
    run_len(5, 3, len);
    chk("op5_len", len, 8);
    tick(1, 0, 0, 0, 0);
    chk("op5_err", s_err, 1);
    run_len(0, 0, len);
    chk("op0_len_after_err", len, 2);
    chk("err_sticky", s_err, 1);

    // halt
    tick(1, 1, 15, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk("halt_step_fetch", s_fetch, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      chk("halted", s_halt, 1);
      chk("halted_ctrl", s_ctrl, 0);
      chk("halted_fetch", s_fetch, 0);
    end
    tick(0, 1, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    chk("post_halt_rst_fetch", s_fetch, 1);
    chk("post_halt_rst_halted", s_halt, 0);
    chk("post_halt_rst_err", s_err, 0);
    chk("post_halt_rst_step", s_step, 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) op = 15;
      else if (r < 10) op = 0;
      else if (r < 20) op = 3;
      else if (r < 26) op = 5;
      else op = int'($urandom_range(0, 14));
      tick(($urandom_range(0, 79) == 0) ? 0 : 1, int'($urandom_range(0, 1)), op,
           int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
